// File: rtl/aes_cim_pkg.sv
// aes_cim_pkg: shared types, constants and round helpers for the AES CIM controller
package aes_cim_pkg;
    localparam int NR     = 10;
    localparam int NPLANE = 8;

    // byte k of the state lives at index 15-k so that byte 0 is the MSB of a 128-bit word
    typedef logic [15:0][7:0] state_t;

    typedef enum logic [2:0] {IDLE, ARK, LATCH, SBOX, MIX} fsm_t;

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // row r of column-major byte k = r + 4c takes the byte from column (c + r) mod 4
    function automatic state_t shift_rows(state_t s);
        state_t r;
        for (int k = 0; k < 16; k++) r[15-k] = s[15 - ((k + 4*(k%4)) % 16)];
        return r;
    endfunction
endpackage

// File: rtl/aes_mix_column.sv
// aes_mix_column: combinational MixColumns on one column {a0,a1,a2,a3}, a0 in the MSB
module aes_mix_column
    import aes_cim_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_i;
    assign col_o = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

// File: rtl/std_aes_cim_ctrl.sv
// std_aes_cim_ctrl: AES-128 round sequencer streaming bit-planes and S-box reads to a CIM array
module std_aes_cim_ctrl
    import aes_cim_pkg::*;
(
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         EN,
    input  logic [127:0] Din,
    input  logic         KDrdy,
    input  logic [7:0]   RIO_00,
    input  logic [7:0]   RIO_01,
    input  logic [7:0]   RIO_02,
    input  logic [7:0]   RIO_03,
    input  logic [7:0]   RIO_04,
    input  logic [7:0]   RIO_05,
    input  logic [7:0]   RIO_06,
    input  logic [7:0]   RIO_07,
    input  logic [7:0]   RIO_08,
    input  logic [7:0]   RIO_09,
    input  logic [7:0]   RIO_10,
    input  logic [7:0]   RIO_11,
    input  logic [7:0]   RIO_12,
    input  logic [7:0]   RIO_13,
    input  logic [7:0]   RIO_14,
    input  logic [7:0]   RIO_15,
    output logic [127:0] Dout,
    output logic         Kvld,
    output logic         Dvld,
    output logic         BSY,
    output logic [2:0]   DEMUX_ADD_00,
    output logic [2:0]   DEMUX_ADD_01,
    output logic [2:0]   DEMUX_ADD_02,
    output logic [2:0]   DEMUX_ADD_03,
    output logic [2:0]   DEMUX_ADD_04,
    output logic [2:0]   DEMUX_ADD_05,
    output logic [2:0]   DEMUX_ADD_06,
    output logic [2:0]   DEMUX_ADD_07,
    output logic [2:0]   DEMUX_ADD_08,
    output logic [2:0]   DEMUX_ADD_09,
    output logic [2:0]   DEMUX_ADD_10,
    output logic [2:0]   DEMUX_ADD_11,
    output logic [2:0]   DEMUX_ADD_12,
    output logic [2:0]   DEMUX_ADD_13,
    output logic [2:0]   DEMUX_ADD_14,
    output logic [2:0]   DEMUX_ADD_15,
    output logic [5:0]   RWL_DEC_ADD_00,
    output logic [5:0]   RWL_DEC_ADD_01,
    output logic [5:0]   RWL_DEC_ADD_02,
    output logic [5:0]   RWL_DEC_ADD_03,
    output logic [5:0]   RWL_DEC_ADD_04,
    output logic [5:0]   RWL_DEC_ADD_05,
    output logic [5:0]   RWL_DEC_ADD_06,
    output logic [5:0]   RWL_DEC_ADD_07,
    output logic [5:0]   RWL_DEC_ADD_08,
    output logic [5:0]   RWL_DEC_ADD_09,
    output logic [5:0]   RWL_DEC_ADD_10,
    output logic [5:0]   RWL_DEC_ADD_11,
    output logic [5:0]   RWL_DEC_ADD_12,
    output logic [5:0]   RWL_DEC_ADD_13,
    output logic [5:0]   RWL_DEC_ADD_14,
    output logic [5:0]   RWL_DEC_ADD_15,
    output logic [15:0]  IN
);
    localparam logic [2:0] PLAST = 3'(NPLANE - 1);
    localparam logic [3:0] RLAST = 4'(NR);
    localparam logic [3:0] RMIX  = 4'(NR - 1);

    state_t          rio, sr, mix, st_d, st_q;
    fsm_t            fsm_q;
    logic [3:0]      rnd_q;
    logic [2:0]      p_q;
    logic [15:0]     in_q;
    logic [15:0][1:0] dmx_q;
    logic [15:0][5:0] rwl_q;
    logic [127:0]    dout_q;
    logic            kvld_q, dvld_q, bsy_q;

    // bit p of every state byte, byte k on lane k
    function automatic logic [15:0] plane(state_t s, logic [2:0] p);
        logic [15:0] v;
        for (int k = 0; k < 16; k++) v[k] = s[15-k][p];
        return v;
    endfunction

    assign rio = {RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07,
                  RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15};
    assign sr  = shift_rows(rio);

    genvar c;
    for (c = 0; c < 4; c++) begin : g_mix
        aes_mix_column u_mix (.col_i(sr[15-4*c -: 4]), .col_o(mix[15-4*c -: 4]));
    end

    // the last round skips MixColumns
    assign st_d = (rnd_q < RMIX) ? mix : sr;

    // round sequencer: ARK planes, latch array result, S-box read, local ShiftRows/MixColumns
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            rnd_q  <= '0;
            p_q    <= '0;
            in_q   <= '0;
            dmx_q  <= '0;
            rwl_q  <= '0;
            dout_q <= '0;
            kvld_q <= 1'b0;
            dvld_q <= 1'b0;
            bsy_q  <= 1'b0;
        end else if (EN) begin
            dvld_q <= 1'b0;
            case (fsm_q)
                IDLE: if (KDrdy) begin
                    st_q   <= Din;
                    kvld_q <= 1'b1;
                    bsy_q  <= 1'b1;
                    rnd_q  <= '0;
                    p_q    <= '0;
                    in_q   <= plane(Din, 3'd0);
                    fsm_q  <= ARK;
                end
                ARK: begin
                    p_q   <= p_q + 3'd1;
                    in_q  <= (p_q == PLAST) ? '0 : plane(st_q, p_q + 3'd1);
                    fsm_q <= (p_q == PLAST) ? LATCH : ARK;
                end
                LATCH: if (rnd_q == RLAST) begin
                    dout_q <= rio;
                    dvld_q <= 1'b1;
                    bsy_q  <= 1'b0;
                    fsm_q  <= IDLE;
                end else begin
                    for (int k = 0; k < 16; k++) begin
                        dmx_q[k] <= rio[15-k][7:6];
                        rwl_q[k] <= rio[15-k][5:0];
                    end
                    fsm_q <= SBOX;
                end
                SBOX: begin
                    dmx_q <= '0;
                    rwl_q <= '0;
                    fsm_q <= MIX;
                end
                MIX: begin
                    st_q  <= st_d;
                    rnd_q <= rnd_q + 4'd1;
                    p_q   <= '0;
                    in_q  <= plane(st_d, 3'd0);
                    fsm_q <= ARK;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign Dout = dout_q;
    assign Kvld = kvld_q;
    assign Dvld = dvld_q;
    assign BSY  = bsy_q;
    assign IN   = in_q;

    assign DEMUX_ADD_00 = {1'b0, dmx_q[0]};
    assign DEMUX_ADD_01 = {1'b0, dmx_q[1]};
    assign DEMUX_ADD_02 = {1'b0, dmx_q[2]};
    assign DEMUX_ADD_03 = {1'b0, dmx_q[3]};
    assign DEMUX_ADD_04 = {1'b0, dmx_q[4]};
    assign DEMUX_ADD_05 = {1'b0, dmx_q[5]};
    assign DEMUX_ADD_06 = {1'b0, dmx_q[6]};
    assign DEMUX_ADD_07 = {1'b0, dmx_q[7]};
    assign DEMUX_ADD_08 = {1'b0, dmx_q[8]};
    assign DEMUX_ADD_09 = {1'b0, dmx_q[9]};
    assign DEMUX_ADD_10 = {1'b0, dmx_q[10]};
    assign DEMUX_ADD_11 = {1'b0, dmx_q[11]};
    assign DEMUX_ADD_12 = {1'b0, dmx_q[12]};
    assign DEMUX_ADD_13 = {1'b0, dmx_q[13]};
    assign DEMUX_ADD_14 = {1'b0, dmx_q[14]};
    assign DEMUX_ADD_15 = {1'b0, dmx_q[15]};

    assign RWL_DEC_ADD_00 = rwl_q[0];
    assign RWL_DEC_ADD_01 = rwl_q[1];
    assign RWL_DEC_ADD_02 = rwl_q[2];
    assign RWL_DEC_ADD_03 = rwl_q[3];
    assign RWL_DEC_ADD_04 = rwl_q[4];
    assign RWL_DEC_ADD_05 = rwl_q[5];
    assign RWL_DEC_ADD_06 = rwl_q[6];
    assign RWL_DEC_ADD_07 = rwl_q[7];
    assign RWL_DEC_ADD_08 = rwl_q[8];
    assign RWL_DEC_ADD_09 = rwl_q[9];
    assign RWL_DEC_ADD_10 = rwl_q[10];
    assign RWL_DEC_ADD_11 = rwl_q[11];
    assign RWL_DEC_ADD_12 = rwl_q[12];
    assign RWL_DEC_ADD_13 = rwl_q[13];
    assign RWL_DEC_ADD_14 = rwl_q[14];
    assign RWL_DEC_ADD_15 = rwl_q[15];
endmodule

// File: tb/tb_std_aes_cim_ctrl.sv
// tb_std_aes_cim_ctrl: directed bench with a behavioural CIM array for key 000102..0f
module tb_std_aes_cim_ctrl;
    logic         CLK = 1'b0, RSTn = 1'b0, EN = 1'b1, KDrdy = 1'b0;
    logic [127:0] Din = '0, Dout;
    logic         Kvld, Dvld, BSY;
    logic [15:0]  IN;
    logic [7:0]   rio [16];
    logic [2:0]   dmx [16];
    logic [5:0]   rwl [16];
    logic [8:0]   aor;

    logic [7:0]   sbox [256];
    logic [7:0]   rk [11][16];
    logic [7:0]   acc [16];
    logic         act;
    int           ph, ar;
    int           total = 0, bad = 0;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    std_aes_cim_ctrl dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .Din(Din), .KDrdy(KDrdy),
        .RIO_00(rio[0]), .RIO_01(rio[1]), .RIO_02(rio[2]), .RIO_03(rio[3]),
        .RIO_04(rio[4]), .RIO_05(rio[5]), .RIO_06(rio[6]), .RIO_07(rio[7]),
        .RIO_08(rio[8]), .RIO_09(rio[9]), .RIO_10(rio[10]), .RIO_11(rio[11]),
        .RIO_12(rio[12]), .RIO_13(rio[13]), .RIO_14(rio[14]), .RIO_15(rio[15]),
        .Dout(Dout), .Kvld(Kvld), .Dvld(Dvld), .BSY(BSY),
        .DEMUX_ADD_00(dmx[0]), .DEMUX_ADD_01(dmx[1]), .DEMUX_ADD_02(dmx[2]), .DEMUX_ADD_03(dmx[3]),
        .DEMUX_ADD_04(dmx[4]), .DEMUX_ADD_05(dmx[5]), .DEMUX_ADD_06(dmx[6]), .DEMUX_ADD_07(dmx[7]),
        .DEMUX_ADD_08(dmx[8]), .DEMUX_ADD_09(dmx[9]), .DEMUX_ADD_10(dmx[10]), .DEMUX_ADD_11(dmx[11]),
        .DEMUX_ADD_12(dmx[12]), .DEMUX_ADD_13(dmx[13]), .DEMUX_ADD_14(dmx[14]), .DEMUX_ADD_15(dmx[15]),
        .RWL_DEC_ADD_00(rwl[0]), .RWL_DEC_ADD_01(rwl[1]), .RWL_DEC_ADD_02(rwl[2]), .RWL_DEC_ADD_03(rwl[3]),
        .RWL_DEC_ADD_04(rwl[4]), .RWL_DEC_ADD_05(rwl[5]), .RWL_DEC_ADD_06(rwl[6]), .RWL_DEC_ADD_07(rwl[7]),
        .RWL_DEC_ADD_08(rwl[8]), .RWL_DEC_ADD_09(rwl[9]), .RWL_DEC_ADD_10(rwl[10]), .RWL_DEC_ADD_11(rwl[11]),
        .RWL_DEC_ADD_12(rwl[12]), .RWL_DEC_ADD_13(rwl[13]), .RWL_DEC_ADD_14(rwl[14]), .RWL_DEC_ADD_15(rwl[15]),
        .IN(IN)
    );

    always #5 CLK = ~CLK;

    // OR of every address bus, zero when no S-box read is being issued
    always_comb begin
        aor = '0;
        for (int k = 0; k < 16; k++) aor = aor | {dmx[k], rwl[k]};
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse and affine map, then the AES-128 key schedule
    task automatic build_tables;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  inv, b, rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            for (int k = 0; k < 16; k++) begin
                t = w[4*r + k/4];
                rk[r][k] = t[31 - 8*(k%4) -: 8];
            end
    endtask

    // array model: gathers IN planes, returns plane-sum ^ round key, then S-box words one cycle after the address
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            act <= 1'b0;
            ph  <= 0;
            ar  <= 0;
            for (int k = 0; k < 16; k++) rio[k] <= 8'h00;
        end else if (EN) begin
            if (!act) begin
                act <= KDrdy && !BSY;
                ph  <= 0;
                ar  <= 0;
            end else begin
                for (int k = 0; k < 16; k++) begin
                    if (ph < 8) acc[k][ph[2:0]] <= IN[k];
                    if (ph == 7) rio[k] <= {IN[k], acc[k][6:0]} ^ rk[ar][k];
                    if (ph == 9) rio[k] <= sbox[{dmx[k][1:0], rwl[k]}];
                end
                act <= !(ar == 10 && ph == 8);
                ph  <= (ph == 10) ? 0 : ph + 1;
                ar  <= (ph == 10) ? ar + 1 : ar;
            end
        end
    end

    task automatic kick(input logic [127:0] d);
        @(posedge CLK); #1;
        Din = d;
        KDrdy = 1'b1;
        @(posedge CLK); #1;
        KDrdy = 1'b0;
    endtask

    task automatic wait_dvld(inout int cnt, output logic busy_ok);
        busy_ok = 1'b1;
        while (cnt < 400) begin
            @(posedge CLK); #1;
            cnt++;
            if (Dvld === 1'b1) return;
            if (BSY !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (Dout !== 128'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", Dout); end
        total++; if (IN !== 16'h0) begin bad++; $display("FAIL reset_in got=%h want=0", IN); end
        total++; if (aor !== 9'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", aor); end
        total++; if (Kvld !== 1'b0) begin bad++; $display("FAIL reset_kvld got=%b want=0", Kvld); end
        total++; if (Dvld !== 1'b0) begin bad++; $display("FAIL reset_dvld got=%b want=0", Dvld); end
        total++; if (BSY !== 1'b0) begin bad++; $display("FAIL reset_bsy got=%b want=0", BSY); end
        RSTn = 1'b1;
        @(posedge CLK); #1;
        total++; if (BSY !== 1'b0) begin bad++; $display("FAIL idle_bsy got=%b want=0", BSY); end
    endtask

    task automatic test_fips;
        int cnt;
        logic ok;
        kick(PT);
        cnt = 1;
        total++; if (Kvld !== 1'b1) begin bad++; $display("FAIL fips_kvld got=%b want=1", Kvld); end
        total++; if (BSY !== 1'b1) begin bad++; $display("FAIL fips_bsy got=%b want=1", BSY); end
        total++; if (IN !== 16'hAAAA) begin bad++; $display("FAIL fips_plane0 got=%h want=aaaa", IN); end
        @(posedge CLK); #1;
        cnt++;
        total++; if (IN !== 16'hCCCC) begin bad++; $display("FAIL fips_plane1 got=%h want=cccc", IN); end
        wait_dvld(cnt, ok);
        total++; if (cnt !== 120) begin bad++; $display("FAIL fips_latency got=%0d want=120", cnt); end
        total++; if (Dout !== CT) begin bad++; $display("FAIL fips_dout got=%h want=%h", Dout, CT); end
        total++; if (BSY !== 1'b0) begin bad++; $display("FAIL fips_bsy_end got=%b want=0", BSY); end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL fips_bsy_run got=%b want=1", ok); end
        @(posedge CLK); #1;
        total++; if (Dvld !== 1'b0) begin bad++; $display("FAIL fips_dvld_pulse got=%b want=0", Dvld); end
        total++; if (Dout !== CT) begin bad++; $display("FAIL fips_dout_hold got=%h want=%h", Dout, CT); end
        total++; if (Kvld !== 1'b1) begin bad++; $display("FAIL fips_kvld_hold got=%b want=1", Kvld); end
    endtask

    task automatic test_midrun_kdrdy;
        int cnt;
        logic ok;
        kick(PT);
        cnt = 1;
        total++; if (Dout !== CT) begin bad++; $display("FAIL mid_dout_prev got=%h want=%h", Dout, CT); end
        repeat (29) begin @(posedge CLK); #1; cnt++; end
        Din = '1;
        KDrdy = 1'b1;
        @(posedge CLK); #1;
        cnt++;
        KDrdy = 1'b0;
        wait_dvld(cnt, ok);
        total++; if (cnt !== 120) begin bad++; $display("FAIL mid_latency got=%0d want=120", cnt); end
        total++; if (Dout !== CT) begin bad++; $display("FAIL mid_dout got=%h want=%h", Dout, CT); end
    endtask

    task automatic test_en_hold;
        int cnt;
        logic ok;
        kick(PT);
        cnt = 1;
        repeat (3) begin @(posedge CLK); #1; cnt++; end
        total++; if (IN !== 16'hFF00) begin bad++; $display("FAIL en_plane3 got=%h want=ff00", IN); end
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            cnt++;
            total++; if (IN !== 16'hFF00 || BSY !== 1'b1) begin bad++; $display("FAIL en_frozen cyc=%0d in=%h bsy=%b want in=ff00 bsy=1", i, IN, BSY); end
        end
        EN = 1'b1;
        wait_dvld(cnt, ok);
        total++; if (cnt !== 125) begin bad++; $display("FAIL en_latency got=%0d want=125", cnt); end
        total++; if (Dout !== CT) begin bad++; $display("FAIL en_dout got=%h want=%h", Dout, CT); end
    endtask

    task automatic test_addr;
        int cnt;
        logic ok;
        logic [127:0] d;
        for (int k = 0; k < 15; k++) d[127 - 8*k -: 8] = 8'(k);
        d[7:0] = 8'hf0;
        kick(d);
        cnt = 1;
        repeat (8) begin @(posedge CLK); #1; cnt++; end
        total++; if (IN !== 16'h0) begin bad++; $display("FAIL addr_in_latch got=%h want=0", IN); end
        @(posedge CLK); #1;
        cnt++;
        total++; if (dmx[0] !== 3'd0 || rwl[0] !== 6'h00) begin bad++; $display("FAIL addr_byte0 got=%h/%h want=0/00", dmx[0], rwl[0]); end
        total++; if (dmx[15] !== 3'd3 || rwl[15] !== 6'h3f) begin bad++; $display("FAIL addr_byte15 got=%h/%h want=3/3f", dmx[15], rwl[15]); end
        total++; if (IN !== 16'h0) begin bad++; $display("FAIL addr_in_sbox got=%h want=0", IN); end
        @(posedge CLK); #1;
        cnt++;
        total++; if (aor !== 9'h0) begin bad++; $display("FAIL addr_mix_zero got=%h want=0", aor); end
        wait_dvld(cnt, ok);
        total++; if (cnt !== 120) begin bad++; $display("FAIL addr_latency got=%0d want=120", cnt); end
    endtask

    task automatic test_reset_midrun;
        int cnt;
        logic ok;
        kick(PT);
        repeat (60) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        total++; if (Dout !== 128'h0) begin bad++; $display("FAIL rst_dout got=%h want=0", Dout); end
        total++; if (IN !== 16'h0 || aor !== 9'h0) begin bad++; $display("FAIL rst_buses in=%h addr=%h want=0", IN, aor); end
        total++; if (Kvld !== 1'b0 || Dvld !== 1'b0 || BSY !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b%b want=000", Kvld, Dvld, BSY); end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (BSY !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", BSY); end
        kick(PT);
        cnt = 1;
        total++; if (Kvld !== 1'b1) begin bad++; $display("FAIL rerun_kvld got=%b want=1", Kvld); end
        wait_dvld(cnt, ok);
        total++; if (cnt !== 120) begin bad++; $display("FAIL rerun_latency got=%0d want=120", cnt); end
        total++; if (Dout !== CT) begin bad++; $display("FAIL rerun_dout got=%h want=%h", Dout, CT); end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_fips();
        test_midrun_kdrdy();
        test_en_hold();
        test_addr();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
